// File: rtl/bcd_sub_serial_pkg.sv
// Shared types and constants for the serial BCD subtractor.
package bcd_sub_serial_pkg;

   localparam int BCD_RADIX = 10;
   localparam int DIGIT_W   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_sub_digit.sv
// Single-digit BCD subtractor with borrow; flags non-BCD operand digits.
module bcd_sub_digit
   import bcd_sub_serial_pkg::*;
(
   input  logic [DIGIT_W-1:0] x,
   input  logic [DIGIT_W-1:0] y,
   input  logic               bin,
   output logic [DIGIT_W-1:0] digit,
   output logic               bout,
   output logic               invalid
);

   // Two extra bits hold the full signed range of x - y - bin for 4-bit inputs.
   logic signed [DIGIT_W+1:0] t;

   // NOTE: combinational blocks use blocking '=' so t is read after it is computed.
   always_comb begin
      t = $signed({2'b00, x}) - $signed({2'b00, y}) - $signed({{(DIGIT_W+1){1'b0}}, bin});
      if (t < 0) begin
         digit = DIGIT_W'(t + (DIGIT_W+2)'(BCD_RADIX));
         bout  = 1'b1;
      end else begin
         digit = DIGIT_W'(t);
         bout  = 1'b0;
      end
      invalid = (x > DIGIT_W'(BCD_RADIX-1)) || (y > DIGIT_W'(BCD_RADIX-1));
   end

endmodule

// File: rtl/bcd_sub_serial.sv
// Digit-serial packed-BCD subtractor: one digit per RUN cycle, LSD first,
// result registered once on entry to DONE.
module bcd_sub_serial
   import bcd_sub_serial_pkg::*;
#(
   parameter int NDIG = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [DIGIT_W*NDIG-1:0] a,
   input  logic [DIGIT_W*NDIG-1:0] b,
   input  logic                    bin,
   output logic                    busy,
   output logic                    done,
   output logic [DIGIT_W*NDIG-1:0] diff,
   output logic                    bout,
   output logic                    err
);

   localparam int W  = DIGIT_W * NDIG;
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q;
   logic [W-1:0]    a_q, b_q, acc_q, acc_next;
   logic            borrow_q, inv_q;
   logic [DIGIT_W-1:0] x, y, dig;
   logic            dig_bout, dig_inv, last;

   assign x    = a_q[idx_q*DIGIT_W +: DIGIT_W];
   assign y    = b_q[idx_q*DIGIT_W +: DIGIT_W];
   assign last = (idx_q == IW'(NDIG-1));

   // Newest digit enters at the top so digit 0 lands in [3:0] after NDIG shifts.
   assign acc_next = (acc_q >> DIGIT_W) | (W'(dig) << (W - DIGIT_W));

   bcd_sub_digit u_digit (
      .x       (x),
      .y       (y),
      .bin     (borrow_q),
      .digit   (dig),
      .bout    (dig_bout),
      .invalid (dig_inv)
   );

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last)  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

   // NOTE: sequential state uses non-blocking '<=' so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         borrow_q <= 1'b0;
         inv_q    <= 1'b0;
         diff     <= '0;
         bout     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q      <= a;
                  b_q      <= b;
                  borrow_q <= bin;
                  idx_q    <= '0;
                  acc_q    <= '0;
                  inv_q    <= 1'b0;
               end
            end
            RUN: begin
               acc_q    <= acc_next;
               borrow_q <= dig_bout;
               inv_q    <= inv_q | dig_inv;
               if (last) begin
                  // An invalid digit anywhere in the operation zeroes the result.
                  err  <= inv_q | dig_inv;
                  diff <= (inv_q | dig_inv) ? '0 : acc_next;
                  bout <= (inv_q | dig_inv) ? 1'b0 : dig_bout;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Scoreboard bench for bcd_sub_serial: directed vectors, expected results queued
// at issue time and checked by an independent monitor on every done pulse.
module tb_bcd_sub_serial;

   localparam int NDIG = 4;
   localparam int W    = 4 * NDIG;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  a, b;
   logic          bin;
   logic          busy, done, bout, err;
   logic [W-1:0]  diff;

   typedef struct packed {
      logic [W-1:0] diff;
      logic         bout;
      logic         err;
   } exp_t;

   exp_t exp_q[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   done_count = 0;

   bcd_sub_serial #(.NDIG(NDIG)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         done_count++;
         if (exp_q.size() == 0) begin
            check("unexpected done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("diff", 32'(diff), 32'(e.diff));
            check("bout", 32'(bout), 32'(e.bout));
            check("err",  32'(err),  32'(e.err));
         end
      end
   end

   // Issue one operation from IDLE, wait for done, then step into the next IDLE cycle.
   task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                        input logic [W-1:0] ediff, input logic ebout, input logic eerr);
      int n;
      exp_t e;
      @(negedge clk);
      a = ia; b = ib; bin = ibin; start = 1'b1;
      e.diff = ediff; e.bout = ebout; e.err = eerr;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (1) begin
         @(posedge clk); #1;
         n++;
         if (done) break;
         if (n == 2) check("busy in RUN", 32'(busy), 32'd1);
         if (n > 20) begin
            check("done timeout", 32'd0, 32'd1);
            break;
         end
      end
      check("latency edges", 32'(n), 32'(NDIG + 1));
      @(posedge clk); #1;
      check("busy after DONE", 32'(busy), 32'd0);
   endtask

   initial begin
      int base;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset diff", 32'(diff), 32'd0);
      check("reset bout", 32'(bout), 32'd0);
      check("reset err",  32'(err),  32'd0);
      @(negedge clk);
      rst = 1'b0;

      do_op(16'h4321, 16'h1234, 1'b0, 16'h3087, 1'b0, 1'b0);
      do_op(16'h1000, 16'h0001, 1'b0, 16'h0999, 1'b0, 1'b0);
      do_op(16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1, 1'b0);
      do_op(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);
      do_op(16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1);
      do_op(16'h0001, 16'h00F0, 1'b1, 16'h0000, 1'b0, 1'b1);
      // Held result must survive the idle gap until the next operation.
      repeat (3) @(posedge clk);
      #1;
      check("diff hold", 32'(diff), 32'h0);
      check("err hold",  32'(err),  32'd1);

      // Mid-RUN start with new operands must be ignored.
      fork
         do_op(16'h5000, 16'h1234, 1'b1, 16'h3765, 1'b0, 1'b0);
         begin
            repeat (3) @(negedge clk);
            a = 16'h9999; b = 16'h0000; bin = 1'b0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join

      // Reset during the second RUN cycle aborts the operation.
      base = done_count;
      @(negedge clk);
      a = 16'h8888; b = 16'h1111; bin = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("busy after abort", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("no done after abort", 32'(done_count - base), 32'd0);
      check("diff after abort", 32'(diff), 32'd0);
      do_op(16'h0500, 16'h0250, 1'b0, 16'h0250, 1'b0, 1'b0);

      // Back-to-back: each start lands in the IDLE cycle right after DONE.
      base = done_count;
      do_op(16'h0042, 16'h0017, 1'b0, 16'h0025, 1'b0, 1'b0);
      do_op(16'h7000, 16'h6999, 1'b1, 16'h0000, 1'b0, 1'b0);
      do_op(16'h0123, 16'h0456, 1'b0, 16'h9667, 1'b1, 1'b0);
      @(posedge clk); #1;
      check("back-to-back done count", 32'(done_count - base), 32'd3);
      check("scoreboard drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL global timeout: got running, required finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bcd_sub_serial.md
BCD_SUB_SERIAL -- requirements
Module: bcd_sub_serial

Interface
REQ-001 Parameter NDIG, default 4, number of BCD digits per operand.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; sampled only while idle.
REQ-005 a  input  4*NDIG  minuend, packed BCD, LSD in bits [3:0].
REQ-006 b  input  4*NDIG  subtrahend, packed BCD, LSD in bits [3:0].
REQ-007 bin  input  1  borrow-in, subtracted at the LSD.
REQ-008 busy  output  1  high while digits are being processed.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 diff  output  4*NDIG  packed BCD result of a - b - bin.
REQ-011 bout  output  1  borrow-out; 1 when a < b + bin, with diff in ten's-complement form.
REQ-012 err  output  1  1 when any digit of a or b captured for this operation is greater than 9.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-014 IDLE with start=1 at an edge: SHALL capture a, b and bin, clear the digit index, go to RUN.
REQ-015 start SHALL be ignored in RUN and DONE, with no effect on the captured operands.
REQ-016 Each RUN cycle SHALL process one digit, LSD first: t = a_d - b_d - borrow.
REQ-017 If t < 0, the digit result SHALL be t + 10 and the next borrow 1; otherwise the digit result SHALL be t and the next borrow 0.
REQ-018 Digit-0 borrow SHALL be the captured bin; each later digit SHALL use the previous digit's borrow.
REQ-019 Processing the digit with index NDIG-1 SHALL move the FSM to DONE; the index SHALL NOT wrap past NDIG-1.
REQ-020 DONE SHALL last exactly one cycle, with done=1, then return to IDLE.
REQ-021 Latency: done SHALL be high in the cycle following the (NDIG+1)th rising edge after start is accepted; NDIG=4 gives 5 edges.
REQ-022 busy SHALL be 1 only in RUN.
REQ-023 diff and bout SHALL update only at the transition into DONE.
REQ-024 diff and bout SHALL hold stable from then until the next accepted start moves the FSM into DONE again.
REQ-025 err SHALL be evaluated on the captured operands and update together with diff and bout.
REQ-026 When err=1, diff SHALL be forced to 0 and bout to 0.
REQ-027 Back-to-back operation: start high in the IDLE cycle right after DONE SHALL be accepted.
REQ-028 Intermediate digit results SHALL live in an internal shift register; diff SHALL NOT be updated digit by digit.

Reset
REQ-029 rst=1 SHALL force state IDLE, digit index 0, busy=0, done=0, diff=0, bout=0, err=0, and clear captured operands and borrow.
REQ-030 rst=1 during RUN or DONE SHALL abort the operation; no done pulse SHALL follow for it.
REQ-031 rst SHALL take priority over start in the same cycle.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (IDLE/RUN/DONE), the constant BCD_RADIX=10, and the digit width constant 4.
REQ-033 One combinational sub-module, bcd_sub_digit, SHALL be used.
- Inputs: 4-bit x, 4-bit y, borrow-in.
- Outputs: 4-bit digit, borrow-out, invalid flag (x>9 or y>9).
- Instantiated once and time-multiplexed across digits.

Verification
REQ-034 a=0x4321, b=0x1234, bin=0 -> diff=0x3087, bout=0, err=0; done exactly 5 edges after start.
REQ-035 a=0x1000, b=0x0001, bin=0 -> diff=0x0999, bout=0 (borrow ripples through three digits).
REQ-036 Underflow and borrow-in at full scale:
- a=0x0000, b=0x0001, bin=0 -> diff=0x9999, bout=1.
- a=0x9999, b=0x9999, bin=1 -> diff=0x9999, bout=1.
REQ-037 a=0x12A4, b=0x0001 -> err=1, diff=0x0000, bout=0, done still pulses.
REQ-038 start pulsed again mid-RUN with different operands -> result matches the first operands.
REQ-039 rst asserted on the 2nd RUN cycle -> busy=0 next cycle, no done pulse; a fresh start afterwards completes normally.
REQ-040 Back-to-back starts on each IDLE cycle -> one done per operation, each with correct diff.
